// File: rtl/xcorr_buf_ctrl.sv
// Ping-pong frame buffer over a 1024-word SDP RAM: one half fills while the other is read back rotated by a lag.
// Define XCORR_BUF_OVR_CNT_EN to add the saturating overrun event counter output ovr_cnt.
module xcorr_buf_ctrl #(
    parameter int FRAME_LEN = 512,
    parameter int DATA_W    = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic [9:0]        ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_cea,
    output logic [9:0]        ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              rd_start,
    input  logic [8:0]        rd_lag,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_ready,
    output logic              busy,
    output logic              overrun
`ifdef XCORR_BUF_OVR_CNT_EN
    ,
    output logic [7:0]        ovr_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [8:0] LAST = 9'(FRAME_LEN - 1);

    state_t     state, state_nxt;
    logic       wr_half;
    logic [8:0] wr_cnt;
    logic [8:0] idx;
    logic [8:0] rd_cnt;
    logic       ceb_last;
    logic       accept;
    logic       rd_done;
    logic       wr_wrap;
    logic       swap;
    logic       ovr_evt;

    assign busy    = (state != IDLE);
    assign ram_oce = 1'b1;
    assign m_data  = ram_dout;

    // Read acceptance is decided on the pre-edge flags, so it always wins a tie with a swap.
    assign wr_wrap = s_valid && (wr_cnt == LAST);
    assign swap    = wr_wrap && !frame_ready && !busy;
    assign ovr_evt = wr_wrap && !swap;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_start && frame_ready) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (rd_cnt == LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_half     <= 1'b0;
            wr_cnt      <= '0;
            ram_cea     <= 1'b0;
            ram_ada     <= '0;
            ram_din     <= '0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            ram_cea <= s_valid;
            if (s_valid) begin
                ram_ada <= {wr_half, wr_cnt};
                ram_din <= s_data;
                wr_cnt  <= wr_wrap ? 9'd0 : wr_cnt + 9'd1;
            end
            if (swap) begin
                wr_half <= ~wr_half;
            end
            if (ovr_evt) begin
                overrun <= 1'b1;
            end
            if (swap) begin
                frame_ready <= 1'b1;
            end else if (accept) begin
                frame_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            rd_cnt   <= '0;
            ram_ceb  <= 1'b0;
            ram_adb  <= '0;
            ceb_last <= 1'b0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ram_ceb  <= (state == READ);
            ceb_last <= rd_done;
            m_valid  <= ram_ceb;
            m_last   <= ceb_last;
            if (accept) begin
                idx    <= ({1'b0, rd_lag} >= 10'(FRAME_LEN)) ? 9'd0 : rd_lag;
                rd_cnt <= '0;
            end else if (state == READ) begin
                ram_adb <= {~wr_half, idx};
                idx     <= (idx == LAST) ? 9'd0 : idx + 9'd1;
                rd_cnt  <= rd_cnt + 9'd1;
            end
        end
    end

`ifdef XCORR_BUF_OVR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_cnt <= '0;
        end else if (ovr_evt && ovr_cnt != 8'hFF) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xcorr_buf_ctrl.sv
// Bench for xcorr_buf_ctrl (FRAME_LEN=8): directed scenarios plus random traffic
// checked against a frame-level reference model; includes a bypass-mode RAM.
module tb_xcorr_buf_ctrl;

    localparam int FL = 8;
    localparam int DW = 18;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [9:0]    ram_ada;
    logic [DW-1:0] ram_din;
    logic          ram_cea;
    logic [9:0]    ram_adb;
    logic          ram_ceb;
    logic          ram_oce;
    logic [DW-1:0] ram_dout;
    logic          rd_start;
    logic [8:0]    rd_lag;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          frame_ready;
    logic          busy;
    logic          overrun;
`ifdef XCORR_BUF_OVR_CNT_EN
    logic [7:0]    ovr_cnt;
`endif

    xcorr_buf_ctrl #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .ram_ada     (ram_ada),
        .ram_din     (ram_din),
        .ram_cea     (ram_cea),
        .ram_adb     (ram_adb),
        .ram_ceb     (ram_ceb),
        .ram_oce     (ram_oce),
        .ram_dout    (ram_dout),
        .rd_start    (rd_start),
        .rd_lag      (rd_lag),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun)
`ifdef XCORR_BUF_OVR_CNT_EN
        ,
        .ovr_cnt     (ovr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bypass-mode SDP RAM: one cycle from read enable to data.
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_cea) ram[ram_ada] <= ram_din;
        if (ram_ceb) ram_dout <= ram[ram_adb];
    end

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame-level view of both halves and the read window.
    int m_half;
    int m_cnt;
    int m_fr;
    int m_ovr;
    int m_oc;
    int m_busy;
    int m_mem [2][FL];
    int exp_wa[$];
    int exp_wd[$];
    int exp_ra[$];
    int exp_md[$];
    int exp_ml[$];

    task automatic model_reset();
        m_half = 0; m_cnt = 0; m_fr = 0; m_ovr = 0; m_oc = 0; m_busy = 0;
        exp_wa.delete(); exp_wd.delete();
        exp_ra.delete(); exp_md.delete(); exp_ml.delete();
    endtask

    task automatic model_step(input bit sv, input int d, input bit st,
                              input int lag);
        bit busy_pre;
        bit fr_pre;
        int base;
        int j;
        busy_pre = (m_busy > 0);
        fr_pre   = (m_fr != 0);
        if (st && fr_pre && !busy_pre) begin
            base = (lag >= FL) ? 0 : lag;
            for (int k = 0; k < FL; k++) begin
                j = (base + k) % FL;
                exp_ra.push_back((1 - m_half) * 512 + j);
                exp_md.push_back(m_mem[1 - m_half][j]);
                exp_ml.push_back(k == FL - 1 ? 1 : 0);
            end
            m_fr   = 0;
            m_busy = FL + 1;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        if (sv) begin
            exp_wa.push_back(m_half * 512 + m_cnt);
            exp_wd.push_back(d);
            m_mem[m_half][m_cnt] = d;
            if (m_cnt == FL - 1) begin
                m_cnt = 0;
                if (!fr_pre && !busy_pre) begin
                    m_half = 1 - m_half;
                    m_fr   = 1;
                end else begin
                    m_ovr = 1;
                    if (m_oc < 255) m_oc++;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle(input bit sv, input int d, input bit st, input int lag);
        s_valid  = sv;
        s_data   = DW'(d);
        rd_start = st;
        rd_lag   = 9'(lag);
        model_step(sv, d, st, lag);
        @(posedge clk);
        #1;
        chk("frame_ready", frame_ready, m_fr);
        chk("busy", busy, (m_busy > 0) ? 1 : 0);
        chk("overrun", overrun, m_ovr);
`ifdef XCORR_BUF_OVR_CNT_EN
        chk("ovr_cnt", ovr_cnt, m_oc);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic hard_reset();
        #1;
        reset    = 1'b1;
        s_valid  = 1'b0;
        rd_start = 1'b0;
        model_reset();
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cea", ram_cea, 0);
        chk("rst_ceb", ram_ceb, 0);
        chk("rst_fr", frame_ready, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Port monitors on the falling edge, against the model's expected streams.
    int e;
    always @(negedge clk) begin
        if (ram_cea) begin
            if (exp_wa.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                e = exp_wa.pop_front();
                chk("ram_ada", ram_ada, e);
                e = exp_wd.pop_front();
                chk("ram_din", ram_din, e);
            end
        end
        if (ram_ceb) begin
            if (exp_ra.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = exp_ra.pop_front();
                chk("ram_adb", ram_adb, e);
            end
        end
        if (m_valid) begin
            if (exp_md.size() == 0) begin
                chk("m_unexpected", 1, 0);
            end else begin
                e = exp_md.pop_front();
                chk("m_data", m_data, e);
                e = exp_ml.pop_front();
                chk("m_last", m_last, e);
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; s_valid = 1'b0; s_data = '0;
        rd_start = 1'b0; rd_lag = '0;
        model_reset();
        hard_reset();
        chk("rst_ada", ram_ada, 0);
        chk("rst_adb", ram_adb, 0);
        chk("rst_din", ram_din, 0);
        chk("oce", ram_oce, 1);

        // Fill one frame with 1..8, then read it back with lag 3.
        for (int i = 1; i <= FL; i++) cycle(1, i, 0, 0);
        chk("fr_after_frame", frame_ready, 1);
        idle(1);
        cycle(0, 0, 1, 3);
        idle(10);
        chk("busy_after_read", busy, 0);

        // Start with no frame ready must be ignored.
        cycle(0, 0, 1, 2);
        chk("ignored_start_busy", busy, 0);
        idle(3);

        // Out-of-range lag starts at index 0.
        for (int i = 0; i < FL; i++) cycle(1, 100 + i, 0, 0);
        cycle(0, 0, 1, 9);
        idle(11);

        // Two frames without a read: second one overruns into the same half.
        hard_reset();
        for (int i = 1; i <= 2 * FL; i++) cycle(1, i, 0, 0);
        chk("ovr_two_frames", overrun, 1);
        chk("fr_two_frames", frame_ready, 1);
`ifdef XCORR_BUF_OVR_CNT_EN
        chk("ovr_cnt_one", ovr_cnt, 1);
`endif
        idle(2);

        // Reset during the fourth READ cycle.
        hard_reset();
        for (int i = 0; i < FL; i++) cycle(1, 40 + i, 0, 0);
        cycle(0, 0, 1, 0);
        idle(3);
        chk("mv_before_rst", m_valid, 1);
        hard_reset();
        cycle(1, 77, 0, 0);
        chk("addr_after_rst", ram_ada, 0);
        idle(12);

`ifdef XCORR_BUF_OVR_CNT_EN
        // Saturation after 300 forced overruns.
        hard_reset();
        for (int f = 0; f < 301; f++)
            for (int i = 0; i < FL; i++) cycle(1, $urandom_range(0, 255), 0, 0);
        chk("ovr_cnt_sat", ovr_cnt, 255);
        idle(2);
`endif

        // Random traffic.
        hard_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  int'($urandom & 32'h3FFFF),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                              : int'($urandom_range(0, 7)));
        end

        for (int n = 0; n < 40; n++) begin
            if (exp_wa.size() == 0 && exp_ra.size() == 0 && exp_md.size() == 0)
                break;
            cycle(0, 0, 0, 0);
        end
        chk("drain_wr", exp_wa.size(), 0);
        chk("drain_rd", exp_ra.size(), 0);
        chk("drain_m", exp_md.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
